// File: rtl/pacman_keys_pkg.sv
// Shared definitions for the Pac-Man keyboard front end.
// Holds the direction encoding (also the bit index of the held mask),
// the PS/2 set-2 arrow scan codes, the prefix-parser state enum and a
// helper that picks the lowest-index held direction.
package pacman_keys_pkg;

    localparam int unsigned CODE_W   = 8;
    localparam int unsigned DIR_W    = 2;
    localparam int unsigned NUM_DIRS = 4;

    // Direction encoding consumed by pacman_motion.req_dir.
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd0;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'd2;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd3;

    // Set-2 arrow make codes (sent after the E0 extended prefix).
    localparam logic [CODE_W-1:0] KEY_RIGHT = 8'h74;
    localparam logic [CODE_W-1:0] KEY_LEFT  = 8'h6B;
    localparam logic [CODE_W-1:0] KEY_UP    = 8'h75;
    localparam logic [CODE_W-1:0] KEY_DOWN  = 8'h72;

    // Prefix parser states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    // Lowest-index set bit of a held mask; DIR_RIGHT when the mask is empty.
    function automatic logic [DIR_W-1:0] lowest_dir(input logic [NUM_DIRS-1:0] mask);
        lowest_dir = DIR_RIGHT;
        for (int i = int'(NUM_DIRS) - 1; i >= 0; i--) begin
            if (mask[i]) lowest_dir = DIR_W'(i);
        end
    endfunction

endpackage

// File: rtl/ps2_arrow_lut.sv
// Combinational arrow scan-code lookup.
// Ports:
//   i_code     - received scan-code byte
//   o_is_arrow - 1 when i_code is one of the four arrow codes
//   o_dir      - direction for the arrow code (don't-care when not an arrow)
module ps2_arrow_lut
    import pacman_keys_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic              o_is_arrow,
    output logic [DIR_W-1:0]  o_dir
);

    always_comb begin
        o_is_arrow = 1'b1;
        o_dir      = DIR_RIGHT;
        case (i_code)
            KEY_RIGHT: o_dir = DIR_RIGHT;
            KEY_LEFT:  o_dir = DIR_LEFT;
            KEY_UP:    o_dir = DIR_UP;
            KEY_DOWN:  o_dir = DIR_DOWN;
            default:   o_is_arrow = 1'b0;
        endcase
    end

endmodule

// File: rtl/pacman_key_decoder.sv
// PS/2 set-2 scan-code decoder for Pac-Man control.
// Parses E0 (extended) and F0 (break) prefixes, tracks which arrow keys are
// held, and produces the requested direction plus start / any-key pulses.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   ps2_byte     - received scan-code byte, qualified by ps2_valid
//   ps2_valid    - one-cycle strobe for ps2_byte
//   req_dir      - requested direction (registered)
//   held         - per-direction key-held mask, bit index = direction
//   start_pulse  - one-cycle pulse on the START_CODE make
//   any_key      - one-cycle pulse on any arrow or START_CODE make
module pacman_key_decoder
    import pacman_keys_pkg::*;
#(
    parameter logic [7:0] START_CODE = 8'h5A,
    parameter logic [7:0] EXT_CODE   = 8'hE0,
    parameter logic [7:0] BRK_CODE   = 8'hF0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CODE_W-1:0]   ps2_byte,
    input  logic                ps2_valid,
    output logic [DIR_W-1:0]    req_dir,
    output logic [NUM_DIRS-1:0] held,
    output logic                start_pulse,
    output logic                any_key
);

    parse_state_t          r_state;
    parse_state_t          w_state_nxt;
    logic [DIR_W-1:0]      r_req_dir;
    logic [DIR_W-1:0]      w_req_dir_nxt;
    logic [NUM_DIRS-1:0]   r_held;
    logic [NUM_DIRS-1:0]   w_held_nxt;
    logic                  r_start_pulse;
    logic                  w_start_pulse_nxt;
    logic                  r_any_key;
    logic                  w_any_key_nxt;

    logic                  w_is_arrow;
    logic [DIR_W-1:0]      w_dir;
    logic [NUM_DIRS-1:0]   w_dir_mask;
    logic [NUM_DIRS-1:0]   w_held_after_brk;

    ps2_arrow_lut u_arrow_lut (
        .i_code     (ps2_byte),
        .o_is_arrow (w_is_arrow),
        .o_dir      (w_dir)
    );

    assign w_dir_mask       = NUM_DIRS'(1) << w_dir;
    assign w_held_after_brk = r_held & ~w_dir_mask;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_dir     <= DIR_LEFT;
            r_held        <= '0;
            r_start_pulse <= 1'b0;
            r_any_key     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_dir     <= w_req_dir_nxt;
            r_held        <= w_held_nxt;
            r_start_pulse <= w_start_pulse_nxt;
            r_any_key     <= w_any_key_nxt;
        end
    end

    // Prefix parser: next state and next output values, only on valid bytes.
    always_comb begin
        w_state_nxt       = r_state;
        w_req_dir_nxt     = r_req_dir;
        w_held_nxt        = r_held;
        w_start_pulse_nxt = 1'b0;
        w_any_key_nxt     = 1'b0;

        if (ps2_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (ps2_byte == EXT_CODE) begin
                        w_state_nxt = ST_EXT;
                    end else if (ps2_byte == BRK_CODE) begin
                        w_state_nxt = ST_BRK;
                    end else if (ps2_byte == START_CODE) begin
                        w_start_pulse_nxt = 1'b1;
                        w_any_key_nxt     = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_byte == BRK_CODE) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        // Make (including typematic repeat) re-asserts the request.
                        if (w_is_arrow) begin
                            w_held_nxt    = r_held | w_dir_mask;
                            w_req_dir_nxt = w_dir;
                            w_any_key_nxt = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    // Non-extended releases carry no arrow information.
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (w_is_arrow && ((r_held & w_dir_mask) != '0)) begin
                        w_held_nxt = w_held_after_brk;
                        // Releasing the active key falls back to another held key;
                        // with nothing held the last request is kept.
                        if ((w_dir == r_req_dir) && (w_held_after_brk != '0)) begin
                            w_req_dir_nxt = lowest_dir(w_held_after_brk);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign req_dir     = r_req_dir;
    assign held        = r_held;
    assign start_pulse = r_start_pulse;
    assign any_key     = r_any_key;

endmodule

// File: tb/tb_pacman_key_decoder.sv
// Self-checking bench for pacman_key_decoder: directed scan-code sequences
// followed by randomized byte streams, checked by a scoreboard fed from a
// byte-sequence reference model.
module tb_pacman_key_decoder;
    import pacman_keys_pkg::*;

    typedef struct packed {
        logic [1:0] req_dir;
        logic [3:0] held;
        logic       start_pulse;
        logic       any_key;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_valid = 1'b0;
    logic [1:0] req_dir;
    logic [3:0] held;
    logic       start_pulse;
    logic       any_key;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model: pending prefix bytes, held keys, current request.
    byte unsigned m_pref[$];
    bit [3:0]     m_held;
    bit [1:0]     m_req;

    pacman_key_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_byte    (ps2_byte),
        .ps2_valid   (ps2_valid),
        .req_dir     (req_dir),
        .held        (held),
        .start_pulse (start_pulse),
        .any_key     (any_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int arrow_dir(input byte unsigned b);
        case (b)
            8'h74:   return 0;
            8'h6B:   return 1;
            8'h75:   return 2;
            8'h72:   return 3;
            default: return -1;
        endcase
    endfunction

    // Apply one valid byte to the model; returns the pulses it produces.
    function automatic void model_byte(input byte unsigned b, output bit st, output bit ak);
        int d;
        st = 1'b0;
        ak = 1'b0;
        if (m_pref.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) m_pref.push_back(b);
            else if (b == 8'h5A) begin
                st = 1'b1;
                ak = 1'b1;
            end
        end else if (m_pref.size() == 1 && m_pref[0] == 8'hE0 && b == 8'hF0) begin
            m_pref.push_back(b);
        end else begin
            d = arrow_dir(b);
            if (d >= 0 && m_pref[0] == 8'hE0) begin
                if (m_pref.size() == 1) begin
                    m_held[d] = 1'b1;
                    m_req     = 2'(d);
                    ak        = 1'b1;
                end else if (m_held[d]) begin
                    m_held[d] = 1'b0;
                    if (int'(m_req) == d && m_held != 4'b0000) begin
                        for (int i = 3; i >= 0; i--) if (m_held[i]) m_req = 2'(i);
                    end
                end
            end
            m_pref.delete();
        end
    endfunction

    // Drive one cycle of input and queue the response expected after that edge.
    task automatic drive(input bit v, input logic [7:0] b);
        bit st;
        bit ak;
        @(negedge clk);
        ps2_valid = v;
        ps2_byte  = b;
        st = 1'b0;
        ak = 1'b0;
        if (v) model_byte(b, st, ak);
        exp_q.push_back({m_req, m_held, st, ak});
    endtask

    // Asynchronous reset pulse entirely between clock edges.
    task automatic do_reset();
        @(negedge clk);
        ps2_valid = 1'b0;
        reset     = 1'b1;
        m_pref.delete();
        m_held = 4'b0000;
        m_req  = DIR_LEFT;
        #2;
        check("rst_req_dir", int'(req_dir), int'(DIR_LEFT));
        check("rst_held", int'(held), 0);
        check("rst_start_pulse", int'(start_pulse), 0);
        check("rst_any_key", int'(any_key), 0);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    // Spec-level end-of-sequence checks, made just after the monitor's sample.
    task automatic expect_now(input string name, input logic [1:0] r, input logic [3:0] h);
        @(posedge clk);
        #2;
        check({name, "_req_dir"}, int'(req_dir), int'(r));
        check({name, "_held"}, int'(held), int'(h));
    endtask

    // Scoreboard monitor: one expected entry per driven cycle.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("req_dir", int'(req_dir), int'(e.req_dir));
            check("held", int'(held), int'(e.held));
            check("start_pulse", int'(start_pulse), int'(e.start_pulse));
            check("any_key", int'(any_key), int'(e.any_key));
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        m_held = 4'b0000;
        m_req  = DIR_LEFT;
        #1;
        do_reset();
        drive(1'b0, 8'h00);

        // Extended RIGHT make.
        send(8'hE0); send(8'h74);
        expect_now("right_make", DIR_RIGHT, 4'b0001);
        drive(1'b0, 8'h00);

        // RIGHT held, UP pressed then released: falls back to RIGHT.
        do_reset();
        send(8'hE0); send(8'h74); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_now("up_release", DIR_RIGHT, 4'b0001);

        // Start key, then its (ignored) non-extended release.
        send(8'h5A); drive(1'b0, 8'h00);
        send(8'hF0); send(8'h5A); drive(1'b0, 8'h5A);

        // Prefix discarded by reset.
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h74);
        expect_now("prefix_discard", DIR_LEFT, 4'b0000);

        // Back-to-back LEFT make and release keeps LEFT.
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
        expect_now("left_b2b", DIR_LEFT, 4'b0000);

        // Typematic repeat and release of a key that is not held.
        send(8'hE0); send(8'h72); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_now("typematic", DIR_DOWN, 4'b1000);

        // Randomized byte stream biased toward meaningful codes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                r = int'($urandom_range(9));
                case (r)
                    0, 1:       b = 8'hE0;
                    2:          b = 8'hF0;
                    3, 4, 5, 6: case ($urandom_range(3))
                                    0: b = 8'h74;
                                    1: b = 8'h6B;
                                    2: b = 8'h75;
                                    default: b = 8'h72;
                                endcase
                    7:          b = 8'h5A;
                    default:    b = 8'($urandom);
                endcase
                drive($urandom_range(3) != 0, b);
            end
        end

        @(negedge clk);
        ps2_valid = 1'b0;
        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
